// File: rtl/cvxif_instr_pkg.sv
// Shared types for the custom vector CV-X-IF extension: op encoding, vector
// length, element type and the execution-unit state encoding.
package cvxif_instr_pkg;

   typedef enum logic [1:0] {
      MV_V_X = 2'd0,
      MV_X_V = 2'd1,
      VADD2  = 2'd2
   } custom_vec_op_e;

   typedef logic [9:0] vlen_t;

   localparam int unsigned VecXlen = 32;
   typedef logic [VecXlen-1:0] vec_elem_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXEC   = 2'd1,
      RESULT = 2'd2
   } vec_exec_state_e;

   // Number of elements actually processed: the requested length capped at the register size.
   function automatic vlen_t clamp_vlen(input vlen_t vlen, input vlen_t max_len);
      if (vlen > max_len) begin
         return max_len;
      end else begin
         return vlen;
      end
   endfunction

endpackage

// File: rtl/cvxif_vec_regfile.sv
// Vector register file: NrVRegs x MaxVlen elements, two combinational element
// read ports and one synchronous element write port, cleared on reset.
module cvxif_vec_regfile import cvxif_instr_pkg::*; #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned NrVRegs = 8,
   parameter int unsigned MaxVlen = 4,
   parameter int unsigned RegW    = $clog2(NrVRegs),
   parameter int unsigned IdxW    = (MaxVlen > 1) ? $clog2(MaxVlen) : 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [RegW-1:0] ra_reg_i,
   input  logic [IdxW-1:0] ra_idx_i,
   output logic [XLEN-1:0] ra_data_o,
   input  logic [RegW-1:0] rb_reg_i,
   input  logic [IdxW-1:0] rb_idx_i,
   output logic [XLEN-1:0] rb_data_o,
   input  logic            we_i,
   input  logic [RegW-1:0] w_reg_i,
   input  logic [IdxW-1:0] w_idx_i,
   input  logic [XLEN-1:0] w_data_i
);

   logic [XLEN-1:0] mem_q [NrVRegs][MaxVlen];

   assign ra_data_o = mem_q[ra_reg_i][ra_idx_i];
   assign rb_data_o = mem_q[rb_reg_i][rb_idx_i];

   // Element storage with a single write port
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int r = 0; r < int'(NrVRegs); r++) begin
            for (int e = 0; e < int'(MaxVlen); e++) begin
               mem_q[r][e] <= {XLEN{1'b0}};
            end
         end
      end else if (we_i) begin
         mem_q[w_reg_i][w_idx_i] <= w_data_i;
      end
   end

endmodule

// File: rtl/cvxif_vec_exec_unit.sv
// Element-serial execution stage for the custom vector ops; owns the vector
// register file and returns one result per accepted op.
module cvxif_vec_exec_unit import cvxif_instr_pkg::*; #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned NrVRegs = 8,
   parameter int unsigned MaxVlen = 4,
   parameter int unsigned IdWidth = 4
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               flush_i,
   input  logic               issue_valid_i,
   output logic               issue_ready_o,
   input  logic [1:0]         issue_op_i,
   input  logic [9:0]         issue_vlen_i,
   input  logic [IdWidth-1:0] issue_id_i,
   input  logic [XLEN-1:0]    issue_rs1_i,
   input  logic [XLEN-1:0]    issue_rs2_i,
   input  logic [4:0]         issue_vd_i,
   input  logic [4:0]         issue_vs1_i,
   input  logic [4:0]         issue_vs2_i,
   input  logic [4:0]         issue_rd_i,
   output logic               result_valid_o,
   input  logic               result_ready_i,
   output logic [IdWidth-1:0] result_id_o,
   output logic [XLEN-1:0]    result_data_o,
   output logic [4:0]         result_rd_o,
   output logic               result_we_o
);

   localparam int unsigned RegW = $clog2(NrVRegs);
   localparam int unsigned IdxW = (MaxVlen > 1) ? $clog2(MaxVlen) : 1;

   vec_exec_state_e    state_q, state_d, state_nxt_s;
   logic [IdxW-1:0]    cnt_q, cnt_d, last_q, last_d;
   logic [RegW-1:0]    vd_q, vd_d, vs1_q, vs1_d, vs2_q, vs2_d;
   logic [IdWidth-1:0] id_q, id_d;
   logic [4:0]         rd_q, rd_d;
   logic [XLEN-1:0]    data_q, data_d;
   logic               we_q, we_d;

   custom_vec_op_e     op_s;
   logic               accept_s;
   vlen_t              n_s;
   logic [IdxW-1:0]    elem_idx_s;
   logic [RegW-1:0]    ra_reg_s;
   logic [IdxW-1:0]    ra_idx_s;
   logic [XLEN-1:0]    ra_data_s, rb_data_s;
   logic               wr_en_s;
   logic [RegW-1:0]    wr_reg_s;
   logic [IdxW-1:0]    wr_idx_s;
   logic [XLEN-1:0]    wr_data_s;

   assign op_s          = custom_vec_op_e'(issue_op_i);
   assign issue_ready_o = (state_q == IDLE) && !flush_i;
   assign accept_s      = issue_valid_i && issue_ready_o;
   assign n_s           = clamp_vlen(issue_vlen_i, vlen_t'(MaxVlen));
   assign elem_idx_s    = issue_rs2_i[IdxW-1:0];

   cvxif_vec_regfile #(
      .XLEN    (XLEN),
      .NrVRegs (NrVRegs),
      .MaxVlen (MaxVlen),
      .RegW    (RegW),
      .IdxW    (IdxW)
   ) i_regfile (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .ra_reg_i  (ra_reg_s),
      .ra_idx_i  (ra_idx_s),
      .ra_data_o (ra_data_s),
      .rb_reg_i  (vs2_q),
      .rb_idx_i  (cnt_q),
      .rb_data_o (rb_data_s),
      .we_i      (wr_en_s),
      .w_reg_i   (wr_reg_s),
      .w_idx_i   (wr_idx_s),
      .w_data_i  (wr_data_s)
   );

   // Read port A serves MV_X_V at accept time and the vs1 operand while executing
   always_comb begin
      if (state_q == EXEC) begin
         ra_reg_s = vs1_q;
         ra_idx_s = cnt_q;
      end else begin
         ra_reg_s = issue_vs1_i[RegW-1:0];
         ra_idx_s = elem_idx_s;
      end
   end

   // Write port: MV_V_X on its accept edge, one VADD2 element per EXEC cycle even when flushed
   always_comb begin
      wr_en_s   = 1'b0;
      wr_reg_s  = issue_vd_i[RegW-1:0];
      wr_idx_s  = elem_idx_s;
      wr_data_s = issue_rs1_i;
      if (state_q == EXEC) begin
         wr_en_s   = 1'b1;
         wr_reg_s  = vd_q;
         wr_idx_s  = cnt_q;
         wr_data_s = ra_data_s + rb_data_s;
      end else if (accept_s && (op_s == MV_V_X)) begin
         wr_en_s = 1'b1;
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // Next-state and result capture
   always_comb begin
      state_nxt_s = state_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      vd_d        = vd_q;
      vs1_d       = vs1_q;
      vs2_d       = vs2_q;
      id_d        = id_q;
      rd_d        = rd_q;
      data_d      = data_q;
      we_d        = we_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               id_d   = issue_id_i;
               rd_d   = issue_rd_i;
               vd_d   = issue_vd_i[RegW-1:0];
               vs1_d  = issue_vs1_i[RegW-1:0];
               vs2_d  = issue_vs2_i[RegW-1:0];
               cnt_d  = {IdxW{1'b0}};
               last_d = IdxW'(n_s - 10'd1);
               data_d = {XLEN{1'b0}};
               we_d   = 1'b0;
               case (op_s)
                  MV_X_V: begin
                     data_d      = ra_data_s;
                     we_d        = 1'b1;
                     state_nxt_s = RESULT;
                  end
                  VADD2: begin
                     state_nxt_s = (n_s == 10'd0) ? RESULT : EXEC;
                  end
                  default: begin
                     state_nxt_s = RESULT;
                  end
               endcase
            end else begin
               state_nxt_s = IDLE;
            end
         end
         EXEC: begin
            if (cnt_q == last_q) begin
               state_nxt_s = RESULT;
            end else begin
               cnt_d = cnt_q + IdxW'(1);
            end
         end
         RESULT: begin
            if (result_ready_i) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RESULT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
      state_d = flush_i ? IDLE : state_nxt_s;
   end

   // State and result registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= {IdxW{1'b0}};
         last_q  <= {IdxW{1'b0}};
         vd_q    <= {RegW{1'b0}};
         vs1_q   <= {RegW{1'b0}};
         vs2_q   <= {RegW{1'b0}};
         id_q    <= {IdWidth{1'b0}};
         rd_q    <= 5'd0;
         data_q  <= {XLEN{1'b0}};
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         vd_q    <= vd_d;
         vs1_q   <= vs1_d;
         vs2_q   <= vs2_d;
         id_q    <= id_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
         we_q    <= we_d;
      end
   end

   assign result_valid_o = (state_q == RESULT);
   assign result_id_o    = id_q;
   assign result_data_o  = data_q;
   assign result_rd_o    = rd_q;
   assign result_we_o    = we_q;

endmodule

// File: tb/tb_cvxif_vec_exec_unit.sv
// Self-checking bench: a register-array model of the vector file plus
// per-cycle expected handshake/result values derived from op latencies.
module tb_cvxif_vec_exec_unit;
   import cvxif_instr_pkg::*;

   localparam int MAXV = 4;

   logic        clk = 1'b0;
   logic        rst_ni, flush, issue_valid, issue_ready, result_valid, result_ready, result_we;
   logic [1:0]  issue_op;
   logic [9:0]  issue_vlen;
   logic [3:0]  issue_id, result_id;
   logic [31:0] issue_rs1, issue_rs2, result_data;
   logic [4:0]  issue_vd, issue_vs1, issue_vs2, issue_rd, result_rd;

   int checks = 0;
   int errors = 0;
   logic [31:0] mdl [8][4];
   logic        check_en = 1'b0;
   logic        exp_ready, exp_valid, exp_we;
   logic [3:0]  exp_id;
   logic [31:0] exp_data;
   logic [4:0]  exp_rd;

   always #5 clk = ~clk;

   cvxif_vec_exec_unit dut (
      .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
      .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_op_i(issue_op),
      .issue_vlen_i(issue_vlen), .issue_id_i(issue_id), .issue_rs1_i(issue_rs1),
      .issue_rs2_i(issue_rs2), .issue_vd_i(issue_vd), .issue_vs1_i(issue_vs1),
      .issue_vs2_i(issue_vs2), .issue_rd_i(issue_rd),
      .result_valid_o(result_valid), .result_ready_i(result_ready), .result_id_o(result_id),
      .result_data_o(result_data), .result_rd_o(result_rd), .result_we_o(result_we)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         chk("issue_ready", 32'(issue_ready), 32'(exp_ready));
         chk("result_valid", 32'(result_valid), 32'(exp_valid));
         if (exp_valid) begin
            chk("result_id", 32'(result_id), 32'(exp_id));
            chk("result_data", result_data, exp_data);
            chk("result_rd", 32'(result_rd), 32'(exp_rd));
            chk("result_we", 32'(result_we), 32'(exp_we));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] op, input logic [3:0] id, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [4:0] vd, input logic [4:0] vs1,
                        input logic [4:0] vs2, input logic [4:0] rd, input logic [9:0] vlen);
      issue_valid = 1'b1; issue_op = op; issue_id = id; issue_rs1 = rs1; issue_rs2 = rs2;
      issue_vd = vd; issue_vs1 = vs1; issue_vs2 = vs2; issue_rd = rd; issue_vlen = vlen;
   endtask

   // Issue one op from IDLE, follow it to the result handshake, update the model.
   task automatic run_op(input logic [1:0] op, input logic [3:0] id, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [4:0] vd, input logic [4:0] vs1,
                         input logic [4:0] vs2, input logic [4:0] rd, input logic [9:0] vlen,
                         input int hold);
      int n, lat, idx;
      logic [31:0] res;
      logic we;
      drive(op, id, rs1, rs2, vd, vs1, vs2, rd, vlen);
      exp_ready = 1'b1; exp_valid = 1'b0;
      step();
      issue_valid = 1'b0;
      n   = (int'(vlen) > MAXV) ? MAXV : int'(vlen);
      idx = int'(rs2[1:0]);
      res = 32'd0; we = 1'b0; lat = 0;
      if (op == MV_V_X) begin
         mdl[vd[2:0]][idx] = rs1;
      end else if (op == MV_X_V) begin
         res = mdl[vs1[2:0]][idx]; we = 1'b1;
      end else begin
         for (int i = 0; i < n; i++) mdl[vd[2:0]][i] = mdl[vs1[2:0]][i] + mdl[vs2[2:0]][i];
         lat = n;
      end
      exp_ready = 1'b0;
      repeat (lat) step();
      exp_valid = 1'b1; exp_id = id; exp_data = res; exp_rd = rd; exp_we = we;
      repeat (hold) step();
      result_ready = 1'b1;
      step();
      result_ready = 1'b0; exp_valid = 1'b0; exp_ready = 1'b1;
   endtask

   task automatic rd_elem(input int r, input int e);
      run_op(MV_X_V, 4'(r + e), 32'd0, 32'(e), 5'd0, 5'(r), 5'd0, 5'(e + 1), 10'd0, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_issue_ready"}, 32'(issue_ready), 32'd1);
      chk({tag, "_result_valid"}, 32'(result_valid), 32'd0);
      chk({tag, "_result_id"}, 32'(result_id), 32'd0);
      chk({tag, "_result_data"}, result_data, 32'd0);
      chk({tag, "_result_rd"}, 32'(result_rd), 32'd0);
      chk({tag, "_result_we"}, 32'(result_we), 32'd0);
   endtask

   initial begin
      rst_ni = 1'b0; flush = 1'b0; issue_valid = 1'b0; result_ready = 1'b0;
      issue_op = 2'd0; issue_vlen = 10'd0; issue_id = 4'd0; issue_rs1 = 32'd0; issue_rs2 = 32'd0;
      issue_vd = 5'd0; issue_vs1 = 5'd0; issue_vs2 = 5'd0; issue_rd = 5'd0;
      exp_ready = 1'b1; exp_valid = 1'b0; exp_we = 1'b0; exp_id = 4'd0; exp_data = 32'd0; exp_rd = 5'd0;
      for (int r = 0; r < 8; r++) for (int e = 0; e < 4; e++) mdl[r][e] = 32'd0;
      #2;
      check_reset_outputs("por");
      @(negedge clk); rst_ni = 1'b1;
      step();
      check_en = 1'b1;

      // Single-element moves
      run_op(MV_V_X, 4'd3, 32'hDEADBEEF, 32'd1, 5'd2, 5'd0, 5'd0, 5'd0, 10'd0, 0);
      run_op(MV_X_V, 4'd7, 32'd0, 32'd1, 5'd0, 5'd2, 5'd0, 5'd5, 10'd0, 0);
      chk("pin_v2_1", mdl[2][1], 32'hDEADBEEF);

      // v1={1,2,3,-1}, v2={10,20,30,1}; VADD2 into v3 with wraparound
      run_op(MV_V_X, 4'd1, 32'd1, 32'd0, 5'd1, 5'd0, 5'd0, 5'd0, 10'd0, 0);
      run_op(MV_V_X, 4'd1, 32'd2, 32'd1, 5'd1, 5'd0, 5'd0, 5'd0, 10'd0, 0);
      run_op(MV_V_X, 4'd1, 32'd3, 32'd2, 5'd1, 5'd0, 5'd0, 5'd0, 10'd0, 0);
      run_op(MV_V_X, 4'd1, 32'hFFFFFFFF, 32'd3, 5'd1, 5'd0, 5'd0, 5'd0, 10'd0, 0);
      run_op(MV_V_X, 4'd2, 32'd10, 32'd0, 5'd2, 5'd0, 5'd0, 5'd0, 10'd0, 0);
      run_op(MV_V_X, 4'd2, 32'd20, 32'd1, 5'd2, 5'd0, 5'd0, 5'd0, 10'd0, 0);
      run_op(MV_V_X, 4'd2, 32'd30, 32'd2, 5'd2, 5'd0, 5'd0, 5'd0, 10'd0, 0);
      run_op(MV_V_X, 4'd2, 32'd1, 32'd3, 5'd2, 5'd0, 5'd0, 5'd0, 10'd0, 0);
      run_op(VADD2, 4'd9, 32'd0, 32'd0, 5'd3, 5'd1, 5'd2, 5'd0, 10'd4, 0);
      for (int e = 0; e < 4; e++) rd_elem(3, e);
      chk("pin_v3_0", mdl[3][0], 32'd11);
      chk("pin_v3_3", mdl[3][3], 32'd0);

      // vlen=2 in place (v3 += v1), vlen=0 no writes, vlen=9 clamped; held result
      run_op(VADD2, 4'd10, 32'd0, 32'd0, 5'd3, 5'd3, 5'd1, 5'd0, 10'd2, 4);
      run_op(VADD2, 4'd11, 32'd0, 32'd0, 5'd3, 5'd1, 5'd1, 5'd0, 10'd0, 0);
      run_op(VADD2, 4'd12, 32'd0, 32'd0, 5'd4, 5'd1, 5'd1, 5'd0, 10'd9, 2);
      for (int e = 0; e < 4; e++) rd_elem(3, e);
      for (int e = 0; e < 4; e++) rd_elem(4, e);
      chk("pin_v3_1", mdl[3][1], 32'd24);
      chk("pin_v3_2", mdl[3][2], 32'd33);
      chk("pin_v4_3", mdl[4][3], 32'hFFFFFFFE);

      // Flush in the 2nd EXEC cycle of VADD2 into v6
      drive(VADD2, 4'd13, 32'd0, 32'd0, 5'd6, 5'd1, 5'd2, 5'd0, 10'd4);
      exp_ready = 1'b1; exp_valid = 1'b0;
      step();
      issue_valid = 1'b0; exp_ready = 1'b0;
      step();
      flush = 1'b1;
      step();
      flush = 1'b0; exp_ready = 1'b1;
      for (int i = 0; i < 2; i++) mdl[6][i] = mdl[1][i] + mdl[2][i];
      repeat (2) step();
      for (int e = 0; e < 4; e++) rd_elem(6, e);
      chk("pin_v6_1", mdl[6][1], 32'd22);
      chk("pin_v6_2", mdl[6][2], 32'd0);

      // Flush with a valid op in IDLE: no accept
      drive(MV_V_X, 4'd14, 32'h00001234, 32'd0, 5'd5, 5'd0, 5'd0, 5'd0, 10'd0);
      flush = 1'b1; exp_ready = 1'b0;
      step();
      flush = 1'b0; issue_valid = 1'b0; exp_ready = 1'b1;
      repeat (2) step();
      rd_elem(5, 0);

      // Randomized ops
      for (int k = 0; k < 60; k++) begin
         run_op(2'($urandom_range(0, 2)), 4'($urandom), $urandom, $urandom,
                5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                10'($urandom_range(0, 9)), int'($urandom_range(0, 3)));
      end

      // Reset in the middle of EXEC
      drive(VADD2, 4'd15, 32'd0, 32'd0, 5'd7, 5'd1, 5'd2, 5'd0, 10'd4);
      exp_ready = 1'b1; exp_valid = 1'b0;
      step();
      issue_valid = 1'b0; exp_ready = 1'b0;
      step();
      check_en = 1'b0;
      rst_ni = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      for (int r = 0; r < 8; r++) for (int e = 0; e < 4; e++) mdl[r][e] = 32'd0;
      @(negedge clk); rst_ni = 1'b1;
      step();
      exp_ready = 1'b1; exp_valid = 1'b0; check_en = 1'b1;
      for (int r = 0; r < 8; r++) for (int e = 0; e < 4; e++) rd_elem(r, e);

      check_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cvxif_vec_exec_unit.md
Name: cvxif_vec_exec_unit

Overview:
- Execution stage for the custom vector CV-X-IF extension. Sits directly downstream of the coprocessor instruction decoder.
- Accepts one decoded op at a time (MV_V_X, MV_X_V, VADD2) with its operands and vector length. Owns the vector register file and executes element-serially.
- Returns one result per accepted op towards the CV-X-IF result interface.

Parameters:
- XLEN, 32, integer register and vector element width in bits
- NrVRegs, 8, number of vector registers (power of two, 2..32)
- MaxVlen, 4, elements per vector register (power of two)
- IdWidth, 4, width of the instruction id

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  abort the in-flight op, drop any pending result
- issue_valid_i  in  1  decoded op valid
- issue_ready_o  out  1  unit can accept an op
- issue_op_i  in  2  custom_vec_op_e
- issue_vlen_i  in  10  vlen_t, element count for VADD2
- issue_id_i  in  IdWidth  instruction id
- issue_rs1_i  in  XLEN  integer rs1 value
- issue_rs2_i  in  XLEN  integer rs2 value; low bits give the element index for MV ops
- issue_vd_i  in  5  destination vector register field (instr[11:7])
- issue_vs1_i  in  5  source vector register field (instr[19:15])
- issue_vs2_i  in  5  source vector register field (instr[24:20])
- issue_rd_i  in  5  integer destination register
- result_valid_o  out  1  result available
- result_ready_i  in  1  result consumed
- result_id_o  out  IdWidth  id of the completed op
- result_data_o  out  XLEN  writeback data; 0 when result_we_o=0
- result_rd_o  out  5  integer destination
- result_we_o  out  1  integer writeback required

Behaviour:
- Register index = low log2(NrVRegs) bits of the 5-bit field. Element index idx = issue_rs2_i[log2(MaxVlen)-1:0].
- Op semantics:
  - MV_V_X: vreg[vd][idx] <= rs1. Result has we=0.
  - MV_X_V: result data = vreg[vs1][idx], we=1.
  - VADD2: vreg[vd][i] <= vreg[vs1][i] + vreg[vs2][i] for i in 0..n-1, with n = min(vlen, MaxVlen). Addition wraps modulo 2^XLEN. Result has we=0.
- FSM states: IDLE, EXEC, RESULT.
- Handshake: issue_ready_o = (state==IDLE) & ~flush_i. An op is accepted on the edge where valid & ready.
- Accept in IDLE at cycle N:
  - The op's id and rd are latched.
  - MV_V_X writes the element and MV_X_V latches its read data, both on the accept edge. Next state is RESULT, so result_valid_o is high in cycle N+1.
  - VADD2 with n>0 goes to EXEC with element counter = 0.
  - VADD2 with n=0 goes to RESULT with no writes (result in cycle N+1).
- EXEC: one element per cycle; element i is written at the end of cycle N+1+i. When the counter reaches n-1, next state is RESULT, so result_valid_o rises in cycle N+1+n.
  - vd == vs1 or vs2 is legal. Each element is read before it is written.
- RESULT: result_* outputs are held stable while valid and not ready. Return to IDLE on result_valid_o & result_ready_i.
  - No new accept in the same cycle; the next accept is possible in the following cycle.
- flush_i (any state): next state IDLE, result_valid_o low from the next cycle.
  - A flush in IDLE blocks acceptance that cycle.
  - Elements already written by a flushed VADD2 remain written; a write scheduled in the flush cycle still completes.
- Reset (asynchronous): state IDLE, counter 0, all vreg elements 0.
  - Output reset values: issue_ready_o=1 and all result_* outputs 0. Reset mid-EXEC abandons the op.
- Only one op is in flight at a time; there is no queueing.

Decomposition:
- Add to cvxif_instr_pkg: vec_exec_state_e (IDLE/EXEC/RESULT) and a vec_elem_t (XLEN-wide) typedef. Reuse the existing custom_vec_op_e and vlen_t.
- Sub-module cvxif_vec_regfile:
  - NrVRegs x MaxVlen flop array, async reset to 0
  - two combinational element read ports
  - one synchronous element write port

Test Plan:
- Reset, then MV_V_X with vd=2, rs2=1, rs1=0xDEADBEEF, id=3 -> result_valid one cycle after accept with id=3, we=0, data=0. A following MV_X_V with vs1=2, rs2=1, rd=5 -> data=0xDEADBEEF, rd=5, we=1.
- Load v1={1,2,3,0xFFFFFFFF} and v2={10,20,30,1} via MV_V_X, then VADD2 with vd=3, vs1=1, vs2=2, vlen=4 -> result_valid exactly 5 cycles after accept. Reading v3 via MV_X_V gives {11,22,33,0}, confirming wraparound.
- VADD2 with vlen=2 (vd=3) -> only elements 0 and 1 written, elements 2 and 3 keep old values, result after 3 cycles. VADD2 with vlen=0 -> result after 1 cycle, no writes. vlen=9 -> clamped to 4.
- Hold result_ready_i=0 for 4 cycles -> result_* stable and issue_ready_o=0 throughout. The accept after the handshake occurs no earlier than the next cycle.
- flush_i during the 2nd EXEC cycle of VADD2 with vlen=4 -> no result, unit back in IDLE next cycle, only elements 0 and 1 updated. flush_i together with issue_valid in IDLE -> no accept.
- Assert rst_ni low mid-EXEC -> all outputs at reset values immediately, and all vreg elements read back 0.
